// File: rtl/rr_mux_reg.sv
// Registered N-to-1 channel mux with valid/ready handshakes.
// Round-robin or forced select feeds a single output register.
module rr_mux_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          force_sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0]   NCH  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS-1);

  logic                  out_valid_q;
  logic [WIDTH-1:0]      out_data_q;
  logic [SEL_W-1:0]      out_sel_q;
  logic [SEL_W-1:0]      rr_ptr_q;
  logic [SEL_W-1:0]      rr_ptr_d;

  logic                  load;
  logic                  xfer;
  logic                  gnt_vld;
  logic [SEL_W-1:0]      gnt_idx;
  logic [SEL_W-1:0]      off;
  logic [SEL_W:0]        sum;
  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic [WIDTH-1:0]      gnt_data;

  assign load = !out_valid_q || out_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    off     = '0;
    sum     = '0;
    dbl     = {in_valid, in_valid} >> rr_ptr_q;
    rot     = dbl[CHANNELS-1:0];
    if (mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (force_sel == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // rot[k] is channel (rr_ptr+k) mod CHANNELS; lowest k wins
      for (int i = CHANNELS-1; i >= 0; i--) begin
        if (rot[i]) begin
          gnt_vld = 1'b1;
          off     = SEL_W'(i);
        end
      end
      sum = {1'b0, rr_ptr_q} + {1'b0, off};
      if (sum >= NCH) sum = sum - NCH;
      gnt_idx = sum[SEL_W-1:0];
    end
  end

  assign xfer = rst_n && load && gnt_vld;

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        in_ready[i] = xfer;
        gnt_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      if (load) begin
        if (xfer) begin
          out_valid_q <= 1'b1;
          out_data_q  <= gnt_data;
          out_sel_q   <= gnt_idx;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      if (xfer && !mode) rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: a 4-channel and a 3-channel
// instance sharing clock and reset.
module tb_rr_mux_reg;

  logic clk;
  logic rst_n;

  logic         a_mode;
  logic [1:0]   a_force_sel;
  logic [3:0]   a_in_valid;
  logic [127:0] a_in_data;
  logic [3:0]   a_in_ready;
  logic         a_out_valid;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_sel;
  logic         a_out_ready;

  logic         b_mode;
  logic [1:0]   b_force_sel;
  logic [2:0]   b_in_valid;
  logic [95:0]  b_in_data;
  logic [2:0]   b_in_ready;
  logic         b_out_valid;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_sel;
  logic         b_out_ready;

  int total;
  int bad;

  rr_mux_reg #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (a_mode),
    .force_sel (a_force_sel),
    .in_valid  (a_in_valid),
    .in_data   (a_in_data),
    .in_ready  (a_in_ready),
    .out_valid (a_out_valid),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel),
    .out_ready (a_out_ready)
  );

  rr_mux_reg #(.WIDTH(32), .CHANNELS(3), .SEL_W(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (b_mode),
    .force_sel (b_force_sel),
    .in_valid  (b_in_valid),
    .in_data   (b_in_data),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel),
    .out_ready (b_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v,
                       input logic [31:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 64'(a_out_valid), 64'(v));
    chk({tag, ".data"}, 64'(a_out_data), 64'(d));
    chk({tag, ".sel"}, 64'(a_out_sel), 64'(s));
  endtask

  task automatic chk_b(input string tag, input logic v,
                       input logic [31:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 64'(b_out_valid), 64'(v));
    chk({tag, ".data"}, 64'(b_out_data), 64'(d));
    chk({tag, ".sel"}, 64'(b_out_sel), 64'(s));
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // reset with random inputs
    rst_n       = 1'b0;
    a_mode      = 1'($urandom);
    a_force_sel = 2'($urandom);
    a_in_valid  = 4'hF;
    a_in_data   = {4{32'($urandom)}};
    a_out_ready = 1'($urandom);
    b_mode      = 1'b0;
    b_force_sel = 2'd0;
    b_in_valid  = 3'b111;
    b_in_data   = {3{32'($urandom)}};
    b_out_ready = 1'b1;
    #2;
    chk("rst.a_rdy", 64'(a_in_ready), 64'h0);
    chk("rst.b_rdy", 64'(b_in_ready), 64'h0);
    chk_a("rst.a", 1'b0, 32'h0, 2'd0);
    chk_b("rst.b", 1'b0, 32'h0, 2'd0);
    tick();
    chk("rst2.a_rdy", 64'(a_in_ready), 64'h0);
    chk_a("rst2.a", 1'b0, 32'h0, 2'd0);

    // release, idle
    a_mode      = 1'b0;
    a_force_sel = 2'd0;
    a_in_valid  = 4'h0;
    b_in_valid  = 3'b000;
    a_out_ready = 1'b1;
    rst_n       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle.a_rdy", 64'(a_in_ready), 64'h0);
      tick();
      chk_a("idle.a", 1'b0, 32'h0, 2'd0);
    end

    // round-robin fairness
    for (int i = 0; i < 4; i++)
      a_in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    a_in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr.rdy", 64'(a_in_ready), 64'(4'b1 << (i % 4)));
      tick();
      chk_a("rr.out", 1'b1, 32'hA0 + 32'(i % 4), 2'(i % 4));
    end

    // backpressure: hold channel 2 word, then ch3 loads on release
    a_in_data[64 +: 32] = 32'h1234_5678;
    a_in_valid = 4'b0100;
    #1;
    chk("bp.rdy0", 64'(a_in_ready), 64'h4);
    tick();
    chk_a("bp.load", 1'b1, 32'h1234_5678, 2'd2);
    a_out_ready = 1'b0;
    a_in_valid  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.stall_rdy", 64'(a_in_ready), 64'h0);
      tick();
      chk_a("bp.hold", 1'b1, 32'h1234_5678, 2'd2);
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp.rel_rdy", 64'(a_in_ready), 64'h8);
    tick();
    chk_a("bp.next", 1'b1, 32'hA3, 2'd3);
    a_in_data[64 +: 32] = 32'hA2;

    // one rr grant to move the pointer to 1
    tick();
    chk_a("pre.force", 1'b1, 32'hA0, 2'd0);

    // forced select channel 1
    a_mode      = 1'b1;
    a_force_sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("frc.rdy", 64'(a_in_ready), 64'h2);
      tick();
      chk_a("frc.out", 1'b1, 32'hA1, 2'd1);
    end

    // back to rr: pointer still at 1
    a_mode = 1'b0;
    #1;
    chk("resume.rdy", 64'(a_in_ready), 64'h2);
    tick();
    chk_a("resume.out", 1'b1, 32'hA1, 2'd1);

    // forced channel not valid: no grant, valid drops
    a_mode      = 1'b1;
    a_force_sel = 2'd2;
    a_in_valid  = 4'b1011;
    #1;
    chk("nog.rdy", 64'(a_in_ready), 64'h0);
    tick();
    chk_a("nog.out", 1'b0, 32'hA1, 2'd1);
    tick();
    chk_a("nog.out2", 1'b0, 32'hA1, 2'd1);

    // 3-channel wrap with channels 0 and 2 valid
    for (int i = 0; i < 3; i++)
      b_in_data[i*32 +: 32] = 32'hB0 + 32'(i);
    b_in_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wrap.rdy", 64'(b_in_ready), (i % 2 == 0) ? 64'h1 : 64'h4);
      tick();
      chk_b("wrap.out", 1'b1, (i % 2 == 0) ? 32'hB0 : 32'hB2,
            (i % 2 == 0) ? 2'd0 : 2'd2);
    end

    // forced index beyond channel count: no grant
    b_mode      = 1'b1;
    b_force_sel = 2'd3;
    b_in_valid  = 3'b111;
    #1;
    chk("oor.rdy", 64'(b_in_ready), 64'h0);
    tick();
    chk_b("oor.out", 1'b0, 32'hB2, 2'd2);

    // reset while holding a stalled word (pointer at 2)
    a_mode     = 1'b0;
    a_in_valid = 4'hF;
    #1;
    chk("mid.rdy", 64'(a_in_ready), 64'h4);
    tick();
    chk_a("mid.load", 1'b1, 32'hA2, 2'd2);
    a_out_ready = 1'b0;
    tick();
    chk_a("mid.stall", 1'b1, 32'hA2, 2'd2);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_rdy", 64'(a_in_ready), 64'h0);
    chk_a("mid.rst", 1'b0, 32'h0, 2'd0);
    #1;
    rst_n       = 1'b1;
    a_out_ready = 1'b1;
    #1;
    chk("post.rdy", 64'(a_in_ready), 64'h1);
    tick();
    chk_a("post.out", 1'b1, 32'hA0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
